// File: rtl/sd_arb_pkg.sv
// sd_arb_pkg: state encoding, operation codes and default watchdog depth for sd_req_arbiter
package sd_arb_pkg;
  typedef enum logic [2:0] {IDLE, REQ, ACKW, XFER, DONE} state_t;
  typedef enum logic {OP_RD, OP_WR} op_t;
  localparam int unsigned DEF_TIMEOUT = 32'd1 << 24;
endpackage

// File: rtl/sd_rr_pick.sv
// sd_rr_pick: combinational round-robin picker, first pending drive at or after ptr with wrap
module sd_rr_pick #(
  parameter int NDRV = 2,
  parameter int GW = 1
)(
  input  logic [NDRV-1:0] pending,
  input  logic [GW-1:0]   ptr,
  output logic [GW-1:0]   gnt,
  output logic            valid
);
  logic [GW:0] idx;
  // scan from the farthest offset down so the nearest pending drive wins last
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = NDRV - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (GW+1)'(i);
      idx = (idx >= (GW+1)'(NDRV)) ? idx - (GW+1)'(NDRV) : idx;
      if (pending[idx[GW-1:0]]) gnt = idx[GW-1:0];
    end
  end
  assign valid = |pending;
endmodule

// File: rtl/sd_req_arbiter.sv
// sd_req_arbiter: round-robin share of the HPS SD sector channel between NDRV drive controllers.
// Define SD_REQ_TIMEOUT_EN to abort requests whose sd_ack never arrives within TIMEOUT cycles.
module sd_req_arbiter
  import sd_arb_pkg::*;
#(
  parameter int NDRV = 2,
  parameter int DW = 8
`ifdef SD_REQ_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = DEF_TIMEOUT
`endif
)(
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic [NDRV-1:0]      drv_rd,
  input  logic [NDRV-1:0]      drv_wr,
  input  logic [32*NDRV-1:0]   drv_lba,
  input  logic [DW*NDRV-1:0]   drv_buff_din,
  output logic [NDRV-1:0]      drv_act,
  output logic [NDRV-1:0]      drv_done,
  output logic [NDRV-1:0]      drv_err,
  output logic [31:0]          sd_lba,
  output logic [NDRV-1:0]      sd_rd,
  output logic [NDRV-1:0]      sd_wr,
  input  logic                 sd_ack,
  output logic [DW-1:0]        sd_buff_din,
  output logic                 busy
);
  localparam int GW = (NDRV > 1) ? $clog2(NDRV) : 1;
  state_t state;
  op_t op;
  logic [GW-1:0] ptr, gnt, pick;
  logic pick_valid, ack_low;
  logic [NDRV-1:0] gnt_oh;
  sd_rr_pick #(.NDRV(NDRV), .GW(GW)) u_pick (
    .pending(drv_rd | drv_wr),
    .ptr(ptr),
    .gnt(pick),
    .valid(pick_valid)
  );
  assign gnt_oh = NDRV'(1) << gnt;
  assign busy = state != IDLE;
  assign sd_buff_din = busy ? drv_buff_din[DW*gnt +: DW] : '0;
`ifdef SD_REQ_TIMEOUT_EN
  logic [31:0] cnt;
`else
  assign drv_err = '0;
`endif
  // ack_low arms the ack detector only after sd_ack has been seen low for this grant
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      state <= IDLE;
      op <= OP_RD;
      ptr <= '0;
      gnt <= '0;
      ack_low <= 1'b0;
      sd_lba <= '0;
      sd_rd <= '0;
      sd_wr <= '0;
      drv_act <= '0;
      drv_done <= '0;
`ifdef SD_REQ_TIMEOUT_EN
      drv_err <= '0;
      cnt <= '0;
`endif
    end else begin
      drv_done <= '0;
`ifdef SD_REQ_TIMEOUT_EN
      drv_err <= '0;
`endif
      case (state)
        IDLE: if (pick_valid) begin
          gnt <= pick;
          op <= drv_rd[pick] ? OP_RD : OP_WR;
          sd_lba <= drv_lba[32*pick +: 32];
          ack_low <= 1'b0;
`ifdef SD_REQ_TIMEOUT_EN
          cnt <= '0;
`endif
          state <= REQ;
        end
        REQ: begin
          sd_rd <= (op == OP_RD) ? gnt_oh : '0;
          sd_wr <= (op == OP_WR) ? gnt_oh : '0;
          ack_low <= ack_low | ~sd_ack;
          state <= ACKW;
        end
        ACKW: if (sd_ack && ack_low) begin
          sd_rd <= '0;
          sd_wr <= '0;
          drv_act <= gnt_oh;
          state <= XFER;
        end
`ifdef SD_REQ_TIMEOUT_EN
        else if (cnt == TIMEOUT - 1) begin
          sd_rd <= '0;
          sd_wr <= '0;
          drv_done <= gnt_oh;
          drv_err <= gnt_oh;
          state <= DONE;
        end
`endif
        else begin
          ack_low <= ack_low | ~sd_ack;
`ifdef SD_REQ_TIMEOUT_EN
          cnt <= cnt + 32'd1;
`endif
        end
        XFER: if (!sd_ack) begin
          drv_act <= '0;
          drv_done <= gnt_oh;
          state <= DONE;
        end
        DONE: begin
          ptr <= (gnt == GW'(NDRV - 1)) ? '0 : gnt + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sd_req_arbiter.sv
// tb_sd_req_arbiter: randomized self-checking bench for sd_req_arbiter against a round-robin model
`timescale 1ns/1ps
module tb_sd_req_arbiter;
  localparam int NDRV = 2;
  localparam int DW = 8;
  logic clk_sys = 1'b0, reset = 1'b1, sd_ack = 1'b0;
  logic [NDRV-1:0] drv_rd = '0, drv_wr = '0;
  logic [32*NDRV-1:0] drv_lba = '0;
  logic [DW*NDRV-1:0] drv_buff_din = '0;
  logic [NDRV-1:0] drv_act, drv_done, drv_err, sd_rd, sd_wr;
  logic [31:0] sd_lba;
  logic [DW-1:0] sd_buff_din;
  logic busy;
  int passed = 0, total = 0, excl_bad = 0, mptr = 0;
  logic [31:0] mlba [NDRV];
  logic [DW-1:0] mbuf [NDRV];

  sd_req_arbiter #(
    .NDRV(NDRV),
    .DW(DW)
`ifdef SD_REQ_TIMEOUT_EN
    , .TIMEOUT(16)
`endif
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .drv_rd(drv_rd),
    .drv_wr(drv_wr),
    .drv_lba(drv_lba),
    .drv_buff_din(drv_buff_din),
    .drv_act(drv_act),
    .drv_done(drv_done),
    .drv_err(drv_err),
    .sd_lba(sd_lba),
    .sd_rd(sd_rd),
    .sd_wr(sd_wr),
    .sd_ack(sd_ack),
    .sd_buff_din(sd_buff_din),
    .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys)
    if ($countones({sd_rd, sd_wr}) > 1) excl_bad++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic set_drive(input int d, input logic [31:0] lba, input logic [DW-1:0] b);
    mlba[d] = lba;
    mbuf[d] = b;
    drv_lba[32*d +: 32] = lba;
    drv_buff_din[DW*d +: DW] = b;
  endtask

  function automatic int rr_expect(input logic [NDRV-1:0] p, input int ptr);
    for (int k = 0; k < NDRV; k++)
      if (p[(ptr + k) % NDRV]) return (ptr + k) % NDRV;
    return -1;
  endfunction

  // HPS side of one sector: waits for the request, acks for len cycles, checks the transfer
  task automatic hps_xfer(input int len, output int who, output bit rd);
    int n;
    logic [NDRV-1:0] oh;
    n = 0;
    who = -1;
    rd = 1'b0;
    while ((sd_rd | sd_wr) == '0 && n < 40) begin
      tick();
      n++;
    end
    total++;
    if ((sd_rd | sd_wr) == '0) begin
      $display("FAIL req_seen: sd_rd=%b sd_wr=%b after %0d cycles, required one request bit", sd_rd, sd_wr, n);
      return;
    end
    passed++;
    who = (sd_rd[1] | sd_wr[1]) ? 1 : 0;
    rd = |sd_rd;
    oh = NDRV'(1) << who;
    total++;
    if ($countones({sd_rd, sd_wr}) != 1 || sd_lba !== mlba[who])
      $display("FAIL req_shape: sd_rd=%b sd_wr=%b sd_lba=%h, required single bit and lba %h", sd_rd, sd_wr, sd_lba, mlba[who]);
    else passed++;
    sd_ack = 1'b1;
    for (int i = 0; i < len; i++) begin
      tick();
      total++;
      if (drv_act !== oh || sd_buff_din !== mbuf[who] || (sd_rd | sd_wr) !== '0)
        $display("FAIL xfer: act=%b buff=%h rd=%b wr=%b, required act=%b buff=%h no request", drv_act, sd_buff_din, sd_rd, sd_wr, oh, mbuf[who]);
      else passed++;
    end
    sd_ack = 1'b0;
    tick();
    total++;
    if (drv_done !== oh || drv_err !== '0 || drv_act !== '0)
      $display("FAIL done_pulse: done=%b err=%b act=%b, required done=%b err=00 act=00", drv_done, drv_err, drv_act, oh);
    else passed++;
    tick();
    total++;
    if (drv_done !== '0 || busy !== 1'b0)
      $display("FAIL done_clear: done=%b busy=%b, required 00 and 0", drv_done, busy);
    else passed++;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_sys);
    #1;
    total++;
    if ({drv_act, drv_done, drv_err, sd_rd, sd_wr, sd_lba, sd_buff_din, busy} !== '0)
      $display("FAIL reset_hold: act=%b done=%b err=%b rd=%b wr=%b lba=%h buff=%h busy=%b, required all 0", drv_act, drv_done, drv_err, sd_rd, sd_wr, sd_lba, sd_buff_din, busy);
    else passed++;
    @(negedge clk_sys);
    reset = 1'b0;
    tick();
    total++;
    if ({drv_act, drv_done, drv_err, sd_rd, sd_wr, sd_lba, sd_buff_din, busy} !== '0)
      $display("FAIL reset_idle: act=%b rd=%b wr=%b lba=%h busy=%b, required all 0", drv_act, sd_rd, sd_wr, sd_lba, busy);
    else passed++;
    mptr = 0;
  endtask

  task automatic test_single_read();
    int act_n;
    act_n = 0;
    set_drive(0, 32'h1234, 8'h3C);
    drv_rd = 2'b01;
    tick();
    total++;
    if (sd_rd !== 2'b00 || busy !== 1'b1) $display("FAIL rd_latency1: sd_rd=%b busy=%b, required 00 and 1", sd_rd, busy);
    else passed++;
    tick();
    total++;
    if (sd_rd !== 2'b01 || sd_lba !== 32'h1234) $display("FAIL rd_latency2: sd_rd=%b sd_lba=%h, required 01 and 00001234", sd_rd, sd_lba);
    else passed++;
    sd_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (drv_act === 2'b01 && drv_done === 2'b00) act_n++;
    end
    sd_ack = 1'b0;
    tick();
    total++;
    if (drv_act !== 2'b00 || drv_done !== 2'b01) $display("FAIL rd_done: act=%b done=%b, required 00 and 01", drv_act, drv_done);
    else passed++;
    tick();
    total++;
    if (drv_done !== 2'b00) $display("FAIL rd_done_width: done=%b, required 00", drv_done);
    else passed++;
    total++;
    if (act_n != 20) $display("FAIL rd_act_cycles: act seen %0d cycles, required 20", act_n);
    else passed++;
    drv_rd = 2'b00;
    mptr = 1;
  endtask

  task automatic test_write_buff();
    int who;
    bit rd;
    set_drive(0, 32'h0000_0AAA, 8'h5A);
    set_drive(1, 32'hDEAD_BEEF, 8'hA5);
    drv_wr = 2'b10;
    hps_xfer(6, who, rd);
    total++;
    if (who != rr_expect(2'b10, mptr) || rd !== 1'b0) $display("FAIL wr_grant: drive %0d rd=%b, required drive 1 write", who, rd);
    else passed++;
    drv_wr = 2'b00;
    mptr = 0;
    total++;
    if (sd_buff_din !== '0) $display("FAIL wr_idle_buff: sd_buff_din=%h, required 00", sd_buff_din);
    else passed++;
  endtask

  task automatic test_rd_then_wr();
    int who;
    bit rd;
    drv_rd = 2'b01;
    drv_wr = 2'b01;
    hps_xfer(3, who, rd);
    total++;
    if (who != 0 || rd !== 1'b1) $display("FAIL rdwr_first: drive %0d rd=%b, required drive 0 read", who, rd);
    else passed++;
    drv_rd = 2'b00;
    hps_xfer(3, who, rd);
    total++;
    if (who != 0 || rd !== 1'b0) $display("FAIL rdwr_second: drive %0d rd=%b, required drive 0 write", who, rd);
    else passed++;
    drv_wr = 2'b00;
    mptr = 1;
  endtask

  task automatic test_alternate();
    int who, exp, prev;
    bit rd;
    int cnt [NDRV];
    cnt = '{default: 0};
    prev = -1;
    drv_rd = 2'b11;
    for (int r = 0; r < 4; r++) begin
      exp = rr_expect(drv_rd | drv_wr, mptr);
      hps_xfer(2, who, rd);
      total++;
      if (who != exp || rd !== 1'b1 || who == prev) $display("FAIL alt_grant%0d: drive %0d rd=%b, required drive %0d read", r, who, rd, exp);
      else passed++;
      if (who >= 0) begin
        cnt[who]++;
        mptr = (who + 1) % NDRV;
      end
      prev = who;
    end
    drv_rd = 2'b00;
    total++;
    if (cnt[0] != 2 || cnt[1] != 2) $display("FAIL alt_fair: counts %0d/%0d, required 2/2", cnt[0], cnt[1]);
    else passed++;
  endtask

  task automatic test_stale_ack();
    int n;
    sd_ack = 1'b1;
    repeat (3) tick();
    total++;
    if (busy !== 1'b0 || drv_act !== '0) $display("FAIL stale_idle: busy=%b act=%b, required 0 and 00", busy, drv_act);
    else passed++;
    drv_rd = 2'b10;
    n = 0;
    while (sd_rd === '0 && n < 10) begin
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (drv_act !== '0 || sd_rd !== 2'b10) $display("FAIL stale_hold%0d: act=%b sd_rd=%b, required 00 and 10", i, drv_act, sd_rd);
      else passed++;
    end
    sd_ack = 1'b0;
    tick();
    sd_ack = 1'b1;
    tick();
    total++;
    if (drv_act !== 2'b10 || sd_rd !== '0) $display("FAIL stale_fresh: act=%b sd_rd=%b, required 10 and 00", drv_act, sd_rd);
    else passed++;
    sd_ack = 1'b0;
    tick();
    total++;
    if (drv_done !== 2'b10) $display("FAIL stale_done: done=%b, required 10", drv_done);
    else passed++;
    tick();
    drv_rd = 2'b00;
    mptr = 0;
  endtask

  task automatic test_drop();
    int who;
    bit rd;
    drv_rd = 2'b01;
    tick();
    drv_rd = 2'b00;
    hps_xfer(4, who, rd);
    total++;
    if (who != 0 || rd !== 1'b1) $display("FAIL drop_kept: drive %0d rd=%b, required drive 0 read", who, rd);
    else passed++;
    mptr = 1;
  endtask

  task automatic test_random();
    int who, exp;
    bit rd, exp_rd;
    for (int r = 0; r < 30; r++) begin
      for (int d = 0; d < NDRV; d++)
        if (!drv_rd[d] && !drv_wr[d] && $urandom_range(0, 1) == 1) begin
          set_drive(d, $urandom, DW'($urandom));
          case ($urandom_range(0, 2))
            0: drv_rd[d] = 1'b1;
            1: drv_wr[d] = 1'b1;
            default: begin
              drv_rd[d] = 1'b1;
              drv_wr[d] = 1'b1;
            end
          endcase
        end
      if ((drv_rd | drv_wr) == '0) drv_wr[r % NDRV] = 1'b1;
      exp = rr_expect(drv_rd | drv_wr, mptr);
      exp_rd = drv_rd[exp];
      hps_xfer($urandom_range(1, 6), who, rd);
      total++;
      if (who != exp || rd !== exp_rd) $display("FAIL rand%0d: drive %0d rd=%b, required drive %0d rd=%b", r, who, rd, exp, exp_rd);
      else passed++;
      if (who >= 0) begin
        if (rd) drv_rd[who] = 1'b0;
        else drv_wr[who] = 1'b0;
        mptr = (who + 1) % NDRV;
      end
    end
    drv_rd = 2'b00;
    drv_wr = 2'b00;
  endtask

  task automatic test_reset_mid();
    int who, n;
    bit rd;
    drv_rd = 2'b01;
    hps_xfer(2, who, rd);
    drv_rd = 2'b00;
    tick();
    drv_rd = 2'b01;
    n = 0;
    while (sd_rd === '0 && n < 10) begin
      tick();
      n++;
    end
    sd_ack = 1'b1;
    repeat (2) tick();
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({drv_act, drv_done, sd_rd, sd_wr, sd_lba, sd_buff_din, busy} !== '0)
      $display("FAIL reset_mid: act=%b done=%b rd=%b wr=%b lba=%h buff=%h busy=%b, required all 0", drv_act, drv_done, sd_rd, sd_wr, sd_lba, sd_buff_din, busy);
    else passed++;
    sd_ack = 1'b0;
    drv_rd = 2'b00;
    @(negedge clk_sys);
    reset = 1'b0;
    mptr = 0;
    drv_rd = 2'b11;
    hps_xfer(2, who, rd);
    total++;
    if (who != rr_expect(2'b11, mptr) || rd !== 1'b1) $display("FAIL reset_ptr: drive %0d, required drive 0", who);
    else passed++;
    drv_rd = 2'b00;
    mptr = 1;
  endtask

`ifdef SD_REQ_TIMEOUT_EN
  task automatic test_timeout();
    int n, w;
    n = 0;
    w = 0;
    sd_ack = 1'b0;
    drv_rd = 2'b01;
    while (sd_rd === '0 && w < 20) begin
      tick();
      w++;
    end
    while (sd_rd !== '0 && n < 100) begin
      tick();
      n++;
    end
    total++;
    if (n != 16) $display("FAIL to_len: sd_rd held %0d cycles, required 16", n);
    else passed++;
    total++;
    if (drv_done !== 2'b01 || drv_err !== 2'b01) $display("FAIL to_pulse: done=%b err=%b, required 01 and 01", drv_done, drv_err);
    else passed++;
    tick();
    total++;
    if (drv_done !== '0 || drv_err !== '0) $display("FAIL to_clear: done=%b err=%b, required 00 and 00", drv_done, drv_err);
    else passed++;
    drv_rd = 2'b00;
    mptr = 1;
  endtask
`endif

  task automatic test_exclusive();
    total++;
    if (excl_bad != 0) $display("FAIL exclusive: %0d cycles with more than one request bit, required 0", excl_bad);
    else passed++;
  endtask

  initial begin
    for (int d = 0; d < NDRV; d++) set_drive(d, 32'h0, '0);
    test_reset();
    test_single_read();
    test_write_buff();
    test_rd_then_wr();
    test_alternate();
    test_stale_ack();
    test_drop();
    test_random();
    test_reset_mid();
`ifdef SD_REQ_TIMEOUT_EN
    test_timeout();
`endif
    test_exclusive();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
